// File: rtl/operand_shifter.sv
// Multi-cycle barrel-shifter substitute for ARM-style operand shifts.
// A request is captured in IDLE, then shifted by up to BITS_PER_CYCLE positions
// per SHIFT cycle, and the result is held in DONE until the consumer takes it.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   request handshake (ready only in IDLE)
//   operand, shamt        value to shift and shift amount (0-255)
//   shift_type            00 LSL, 01 LSR, 10 ASR, 11 ROR
//   carry_in              current C flag, used when the effective count is zero
//   flush                 synchronous abort, beats both handshakes
//   out_valid / out_ready result handshake (valid only in DONE)
//   result, carry_out     shifted value and shifter carry

module operand_shifter #(
    parameter int unsigned BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] operand,
    input  logic [7:0]  shamt,
    input  logic [1:0]  shift_type,
    input  logic        carry_in,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        carry_out
);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    localparam logic [1:0] Lsl = 2'b00;
    localparam logic [1:0] Lsr = 2'b01;
    localparam logic [1:0] Asr = 2'b10;
    localparam logic [1:0] Ror = 2'b11;
    localparam logic [5:0] StepMax = 6'(BITS_PER_CYCLE);

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;      // value being shifted
    logic        work_c_q, work_c_d;  // running carry
    logic [1:0]  type_q, type_d;
    logic [5:0]  rem_q, rem_d;        // positions still to shift
    logic [31:0] result_q, result_d;
    logic        carry_q, carry_d;

    logic        accept;
    logic [5:0]  n_eff;
    logic [5:0]  step_k;
    logic        last_step;
    logic [63:0] step_wide;
    logic [31:0] step_val;
    logic        step_c;

    assign accept    = in_valid & in_ready;
    assign step_k    = (rem_q < StepMax) ? rem_q : StepMax;
    assign last_step = (rem_q == step_k);

    // Effective count: LSL/LSR saturate at 33 (one past full width gives carry 0),
    // ASR at 32 (further shifts change nothing), ROR wraps.
    always_comb begin
        n_eff = '0;
        unique case (shift_type)
            Lsl, Lsr: n_eff = (shamt > 8'd33) ? 6'd33 : shamt[5:0];
            Asr:      n_eff = (shamt > 8'd32) ? 6'd32 : shamt[5:0];
            Ror:      n_eff = {1'b0, shamt[4:0]};
            default:  n_eff = '0;
        endcase
    end

    // One shift step of step_k positions. The 64-bit window keeps the last bit
    // shifted out adjacent to the kept half so the carry falls out directly.
    always_comb begin
        step_wide = '0;
        step_val  = work_q;
        step_c    = work_c_q;
        unique case (type_q)
            Lsl: begin
                step_wide = {32'b0, work_q} << step_k;
                step_val  = step_wide[31:0];
                step_c    = step_wide[32];
            end
            Lsr: begin
                step_wide = {work_q, 32'b0} >> step_k;
                step_val  = step_wide[63:32];
                step_c    = step_wide[31];
            end
            Asr: begin
                step_wide = $signed({work_q, 32'b0}) >>> step_k;
                step_val  = step_wide[63:32];
                step_c    = step_wide[31];
            end
            Ror: begin
                step_wide = {work_q, work_q} >> step_k;
                step_val  = step_wide[31:0];
                step_c    = step_wide[31];
            end
            default: ;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = StIdle;
        end else begin
            unique case (state_q)
                StIdle:  if (accept) state_d = (n_eff == 6'd0) ? StDone : StShift;
                StShift: if (last_step) state_d = StDone;
                StDone:  if (out_ready) state_d = StIdle;
                default: state_d = StIdle;
            endcase
        end
    end

    // Outputs
    always_comb begin
        in_ready  = (state_q == StIdle);
        out_valid = (state_q == StDone);
        result    = result_q;
        carry_out = carry_q;
    end

    // Datapath next-state; result/carry_out only change on entry to DONE or on flush.
    always_comb begin
        work_d   = work_q;
        work_c_d = work_c_q;
        type_d   = type_q;
        rem_d    = rem_q;
        result_d = result_q;
        carry_d  = carry_q;
        if (flush) begin
            rem_d    = '0;
            result_d = '0;
            carry_d  = 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (accept) begin
                        work_d   = operand;
                        work_c_d = carry_in;
                        type_d   = shift_type;
                        rem_d    = n_eff;
                        if (n_eff == 6'd0) begin
                            result_d = operand;
                            // ROR by a nonzero multiple of 32 behaves like ROR #32.
                            carry_d  = (shift_type == Ror && shamt != 8'd0) ? operand[31]
                                                                            : carry_in;
                        end
                    end
                end
                StShift: begin
                    work_d   = step_val;
                    work_c_d = step_c;
                    rem_d    = rem_q - step_k;
                    if (last_step) begin
                        result_d = step_val;
                        carry_d  = step_c;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            work_q   <= '0;
            work_c_q <= 1'b0;
            type_q   <= '0;
            rem_q    <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            work_q   <= work_d;
            work_c_q <= work_c_d;
            type_q   <= type_d;
            rem_q    <= rem_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

endmodule
